// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes ALU control, registers operands and control bits,
// and drives the ALU operand ports through EX-stage forwarding muxes.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [31:0]       inst_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [1:0]        fwd_a_i,
    input  logic [1:0]        fwd_b_i,
    input  logic [DATA_W-1:0] ex_mem_data_i,
    input  logic [DATA_W-1:0] mem_wb_data_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              valid_o,
    output logic              illegal_o
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       use_inst;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r;
    logic       is_i;
    logic       is_ld;
    logic       is_st;
    logic       legal;
    ctrl_t      ctrl_d;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LOAD);
    assign is_st  = (opcode == OP_STORE);

    always_comb begin
        ctrl_d = '0;
        legal  = 1'b1;
        unique case (1'b1)
            is_r && funct7 == 7'b0000000 && funct3 == 3'b111:
                ctrl_d = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            is_r && funct7 == 7'b0000000 && funct3 == 3'b100:
                ctrl_d = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            is_r && funct7 == 7'b0000000 && funct3 == 3'b001:
                ctrl_d = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            is_r && funct7 == 7'b0000000 && funct3 == 3'b000:
                ctrl_d = '{4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            is_r && funct7 == 7'b0100000 && funct3 == 3'b000:
                ctrl_d = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            is_r && funct7 == 7'b0000001 && funct3 == 3'b000:
                ctrl_d = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            is_i && funct3 == 3'b000:
                ctrl_d = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            is_i && funct3 == 3'b101 && funct7 == 7'b0100000:
                ctrl_d = '{4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            is_ld && funct3 == 3'b010:
                ctrl_d = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            is_st && funct3 == 3'b010:
                ctrl_d = '{4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            default:
                legal = 1'b0;
        endcase
    end

    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [31:0]       inst_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic              valid_q;
    logic              illegal_q;

    // Stall holds everything; an illegal encoding becomes a flagged bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            inst_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (!stall_i) begin
            if (flush_i || !valid_i || !legal) begin
                ctrl_q     <= '0;
                rs1_data_q <= '0;
                rs2_data_q <= '0;
                inst_q     <= '0;
                rs1_q      <= '0;
                rs2_q      <= '0;
                rd_q       <= '0;
                valid_q    <= 1'b0;
                illegal_q  <= !flush_i && valid_i && !legal;
            end else begin
                ctrl_q     <= ctrl_d;
                rs1_data_q <= rs1_data_i;
                rs2_data_q <= rs2_data_i;
                inst_q     <= inst_i;
                rs1_q      <= inst_i[19:15];
                rs2_q      <= inst_i[24:20];
                rd_q       <= inst_i[11:7];
                valid_q    <= 1'b1;
                illegal_q  <= 1'b0;
            end
        end
    end

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    always_comb begin
        fwd_a = rs1_data_q;
        fwd_b = rs2_data_q;
        if (fwd_a_i == 2'b10) fwd_a = ex_mem_data_i;
        else if (fwd_a_i == 2'b01) fwd_a = mem_wb_data_i;
        if (fwd_b_i == 2'b10) fwd_b = ex_mem_data_i;
        else if (fwd_b_i == 2'b01) fwd_b = mem_wb_data_i;
    end

    assign alu_data1_o  = fwd_a;
    assign alu_data2_o  = ctrl_q.use_inst ? inst_q : fwd_b;
    assign store_data_o = fwd_b;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign rd_o         = rd_q;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign valid_o      = valid_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode table, forwarding,
// stall/flush, illegal encodings and asynchronous reset.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] inst_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [1:0]  fwd_a_i;
    logic [1:0]  fwd_b_i;
    logic [31:0] ex_mem_data_i;
    logic [31:0] mem_wb_data_i;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] store_data_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        mem_to_reg_o;
    logic        valid_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .inst_i(inst_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i),
        .ex_mem_data_i(ex_mem_data_i),
        .mem_wb_data_i(mem_wb_data_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
        .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .valid_o(valid_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        v;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] em;
        logic [31:0] mw;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] st;
        logic [4:0]  i1;
        logic [4:0]  i2;
        logic [4:0]  ird;
        logic [5:0]  fl;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ctrl,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] st, input logic [4:0] i1,
                           input logic [4:0] i2, input logic [4:0] ird,
                           input logic [5:0] fl);
        chk({tag, ".ctrl"}, 32'(alu_ctrl_o), 32'(ctrl));
        chk({tag, ".d1"}, alu_data1_o, d1);
        chk({tag, ".d2"}, alu_data2_o, d2);
        chk({tag, ".st"}, store_data_o, st);
        chk({tag, ".idx"}, 32'({rs1_o, rs2_o, rd_o}),
            32'({i1, i2, ird}));
        chk({tag, ".flags"},
            32'({reg_write_o, mem_read_o, mem_write_o,
                 mem_to_reg_o, valid_o, illegal_o}), 32'(fl));
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] r1,
                         input logic [31:0] r2, input logic v);
        inst_i     = inst;
        rs1_data_i = r1;
        rs2_data_i = r2;
        valid_i    = v;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // {inst, rs1, rs2, valid, fa, fb, ex_mem, mem_wb,
        //  ctrl, d1, d2, store, rs1, rs2, rd, {rw,mr,mw,m2r,v,ill}}
        vecs[0]  = '{32'h002081B3, 5, 7, 1, 0, 0, 0, 0,
                     4'h3, 5, 7, 7, 1, 2, 3, 6'b100010};
        vecs[1]  = '{32'hFFF08093, 10, 20, 1, 0, 0, 0, 0,
                     4'h6, 10, 32'hFFF08093, 20, 1, 31, 1, 6'b100010};
        vecs[2]  = '{32'h0020A423, 100, 32'hAB, 1, 0, 0, 0, 0,
                     4'h8, 100, 32'h0020A423, 32'hAB, 1, 2, 8, 6'b001010};
        vecs[3]  = '{32'h402081B3, 9, 4, 1, 0, 0, 0, 0,
                     4'h4, 9, 4, 4, 1, 2, 3, 6'b100010};
        vecs[4]  = '{32'h022081B3, 6, 7, 1, 0, 0, 0, 0,
                     4'h5, 6, 7, 7, 1, 2, 3, 6'b100010};
        vecs[5]  = '{32'h0020F1B3, 6, 7, 1, 0, 0, 0, 0,
                     4'h0, 6, 7, 7, 1, 2, 3, 6'b100010};
        vecs[6]  = '{32'h0020C1B3, 6, 7, 1, 0, 0, 0, 0,
                     4'h1, 6, 7, 7, 1, 2, 3, 6'b100010};
        vecs[7]  = '{32'h002091B3, 6, 7, 1, 0, 0, 0, 0,
                     4'h2, 6, 7, 7, 1, 2, 3, 6'b100010};
        vecs[8]  = '{32'h4030D093, 32'hFFFFFFF8, 1, 1, 0, 0, 0, 0,
                     4'h7, 32'hFFFFFFF8, 32'h4030D093, 1, 1, 3, 1,
                     6'b100010};
        vecs[9]  = '{32'h0040A283, 32'h1000, 3, 1, 0, 0, 0, 0,
                     4'h6, 32'h1000, 32'h0040A283, 3, 1, 4, 5,
                     6'b110110};
        vecs[10] = '{32'h0000006F, 5, 7, 1, 0, 0, 0, 0,
                     4'h0, 0, 0, 0, 0, 0, 0, 6'b000001};
        vecs[11] = '{32'h002081B3, 5, 7, 1, 0, 0, 0, 0,
                     4'h3, 5, 7, 7, 1, 2, 3, 6'b100010};
        vecs[12] = '{32'h002081B3, 5, 7, 0, 0, 0, 0, 0,
                     4'h0, 0, 0, 0, 0, 0, 0, 6'b000000};
        vecs[13] = '{32'h002081B3, 1, 2, 1, 2'b10, 2'b01, 9, 4,
                     4'h3, 9, 4, 4, 1, 2, 3, 6'b100010};
        vecs[14] = '{32'hFFF08093, 10, 20, 1, 0, 2'b10, 32'h55, 0,
                     4'h6, 10, 32'hFFF08093, 32'h55, 1, 31, 1,
                     6'b100010};
        vecs[15] = '{32'h00408283, 1, 2, 1, 0, 0, 0, 0,
                     4'h0, 0, 0, 0, 0, 0, 0, 6'b000001};
        vecs[16] = '{32'h4020F1B3, 1, 2, 1, 0, 0, 0, 0,
                     4'h0, 0, 0, 0, 0, 0, 0, 6'b000001};
        vecs[17] = '{32'h0020A423, 100, 32'hAB, 1, 2'b01, 0, 0, 32'h33,
                     4'h8, 32'h33, 32'h0020A423, 32'hAB, 1, 2, 8,
                     6'b001010};

        rst_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        fwd_a_i = 2'b00;
        fwd_b_i = 2'b00;
        ex_mem_data_i = 0;
        mem_wb_data_i = 0;
        drive(32'h002081B3, 5, 7, 1'b1);
        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 6'b0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].inst, vecs[i].r1, vecs[i].r2, vecs[i].v);
            fwd_a_i = vecs[i].fa;
            fwd_b_i = vecs[i].fb;
            ex_mem_data_i = vecs[i].em;
            mem_wb_data_i = vecs[i].mw;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].d1,
                    vecs[i].d2, vecs[i].st, vecs[i].i1, vecs[i].i2,
                    vecs[i].ird, vecs[i].fl);
        end

        fwd_a_i = 0;
        fwd_b_i = 0;
        ex_mem_data_i = 9;
        mem_wb_data_i = 4;
        drive(32'h002081B3, 1, 2, 1'b1);
        tick();
        chk("fwd00", alu_data1_o, 1);
        fwd_a_i = 2'b10; #1;
        chk("fwd10", alu_data1_o, 9);
        fwd_a_i = 2'b01; #1;
        chk("fwd01", alu_data1_o, 4);
        fwd_a_i = 2'b11; #1;
        chk("fwd11", alu_data1_o, 1);
        fwd_a_i = 2'b00;
        drive(32'hFFF08093, 1, 2, 1'b1);
        tick();
        fwd_b_i = 2'b10; #1;
        chk("fwd_imm", alu_data2_o, 32'hFFF08093);
        chk("fwd_imm_st", store_data_o, 9);
        fwd_b_i = 2'b00;

        drive(32'h402081B3, 9, 4, 1'b1);
        tick();
        chk("sub_cap", 32'(alu_ctrl_o), 4);
        stall_i = 1'b1;
        flush_i = 1'b1;
        drive(32'h0000006F, 32'hDEAD, 32'hBEEF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d.ctrl", c), 32'(alu_ctrl_o), 4);
            chk($sformatf("stall%0d.v", c),
                32'({valid_o, illegal_o, reg_write_o}), 32'b101);
            chk($sformatf("stall%0d.d1", c), alu_data1_o, 9);
        end
        fwd_a_i = 2'b10;
        ex_mem_data_i = 32'h77; #1;
        chk("stall_fwd", alu_data1_o, 32'h77);
        fwd_a_i = 2'b00;
        stall_i = 1'b0;
        tick();
        chk_all("flush", 0, 0, 0, 0, 0, 0, 0, 6'b0);
        flush_i = 1'b0;

        drive(32'h022081B3, 6, 7, 1'b1);
        tick();
        chk("mul_cap", 32'(alu_ctrl_o), 5);
        stall_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 6'b0);
        stall_i = 1'b0;
        drive(32'h002081B3, 5, 7, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        chk_all("post_rst", 4'h3, 5, 7, 7, 1, 2, 3, 6'b100010);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that feeds the EX-stage ALU. Each cycle it registers a decoded instruction with its register-file operands, generates the 4-bit ALU control code and the MEM/WB control bits, and drives the ALU operand ports through EX-stage forwarding muxes. It supports stall (freeze) and flush (bubble insertion), and flags unsupported encodings.

## Interface
- DATA_W, 32, datapath width; only 32 is supported.
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  hold all stage registers (cache miss or load-use hazard)
- flush_i  in  1  load a bubble instead of the incoming instruction
- valid_i  in  1  ID slot holds a real instruction
- inst_i  in  32  instruction word from IF/ID
- rs1_data_i, rs2_data_i  in  32 each  register-file read data
- fwd_a_i, fwd_b_i  in  2 each  forwarding select, live in EX: 00 = registered operand, 10 = EX/MEM result, 01 = MEM/WB result, 11 = same as 00
- ex_mem_data_i, mem_wb_data_i  in  32 each  forwarding sources
- alu_data1_o, alu_data2_o  out  32 each  ALU operands
- alu_ctrl_o  out  4  ALU operation code
- store_data_o  out  32  forwarded rs2 value for sw
- rs1_o, rs2_o, rd_o  out  5 each  registered register indices (inst[19:15], inst[24:20], inst[11:7])
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  downstream control
- valid_o  out  1  EX slot holds a real instruction
- illegal_o  out  1  EX slot came from an unsupported encoding

## Operation
- Decoding is combinational on inst_i. Results are registered with the operands.
- R-type (opcode 0110011), keyed by funct7/funct3. All set reg_write.
  - 0000000/111 and -> 0000
  - 0000000/100 xor -> 0001
  - 0000000/001 sll -> 0010
  - 0000000/000 add -> 0011
  - 0100000/000 sub -> 0100
  - 0000001/000 mul -> 0101
- I-type ALU (0010011). Both set reg_write.
  - funct3 000 addi -> 0110
  - funct3 101 with funct7 0100000 srai -> 0111
- lw (0000011, funct3 010) -> 0110. Sets reg_write, mem_read and mem_to_reg.
- sw (0100011, funct3 010) -> 1000. Sets mem_write only.
- Operand 2 selection:
  - R-type: forwarded rs2.
  - I, load and S types: the registered raw instruction word. The ALU extracts the immediate or shift amount itself.
  - Forwarding never applies to the instruction word.
- Operand 1 is always forwarded rs1.
- store_data_o is always forwarded rs2, whatever the type.
- Any other encoding with valid_i = 1 is captured as a bubble with illegal_o = 1 for that slot. A bubble has valid_o = 0, all control bits 0 and alu_ctrl_o = 0000.
- Register update priority at each rising edge:
  1. stall_i: all registers hold, including illegal_o. Flush is ignored; upstream keeps flush_i asserted until the stall clears.
  2. flush_i or !valid_i: load a bubble. Data and index registers go to 0 and illegal_o goes to 0.
  3. Otherwise: capture the instruction.
- Forwarding muxes are combinational from the registered operands and the live fwd/data inputs. They are not frozen by stall, so forwarding re-evaluates during a stall.

## Timing
- Latency is one cycle: the instruction captured at edge N appears on the outputs after edge N.
- Reset is asynchronous. All registered outputs go to 0 immediately: alu_ctrl_o = 0000, valid_o = 0, illegal_o = 0, all control bits 0, indices 0. alu_data1_o and alu_data2_o then follow the muxes over zeroed registers.
- Reset asserted mid-stall or mid-flush discards the held instruction. After reset deasserts, the first edge with valid_i = 1 captures normally.
- No combinational path from inst_i, rs*_data_i, stall_i or flush_i to any output. The only combinational paths are fwd_*_i and ex_mem/mem_wb data into alu_data*_o and store_data_o.

## Test plan
- add: inst 0x002081B3 (add x3,x1,x2), rs1 = 5, rs2 = 7, fwd 00. After one edge: alu_ctrl_o = 0011, data1 = 5, data2 = 7, rd_o = 3, reg_write_o = 1, valid_o = 1.
- Immediate and store operand 2: inst 0xFFF08093 (addi x1,x1,-1) -> alu_ctrl_o = 0110, alu_data2_o = 0xFFF08093. inst 0x0020A423 (sw x2,8(x1)) with rs2 = 0xAB -> alu_ctrl_o = 1000, store_data_o = 0xAB, mem_write_o = 1, reg_write_o = 0.
- Forwarding: registered rs1 = 1, ex_mem = 9, mem_wb = 4. fwd_a = 10 -> data1 = 9; fwd_a = 01 -> 4; fwd_a = 11 -> 1. For an addi, fwd_b = 10 leaves alu_data2_o equal to the instruction word.
- Stall and flush: capture sub (alu_ctrl_o = 0100), then assert stall_i and flush_i together for 3 cycles. Outputs hold 0100 with valid_o = 1 throughout. Release stall_i with flush_i still high: the next edge gives valid_o = 0, alu_ctrl_o = 0000.
- Illegal: inst 0x0000006F (jal). After one edge: illegal_o = 1, valid_o = 0, all control bits 0. The following legal instruction clears illegal_o.
- Asynchronous reset: assert rst_i between clock edges while a mul is held. All outputs read 0 before the next edge.
